// File: rtl/ad2dma_stream_arbiter.sv
// ad2dma_stream_arbiter
// Shares one DMA-bound AXI-Stream master between two ADC sample streams.
// Whole packets of cfg_pkt_len beats are granted round-robin. Each beat is
// tagged with its source channel, and m_tlast marks the final beat. A
// per-packet stall watchdog reports which channel is stuck and why.
//
// Ports:
//   clock, reset            sole clock; asynchronous active-high reset
//   cfg_enable              allow new packet grants
//   cfg_pkt_len             beats per packet (0 behaves as 1)
//   cfg_timeout             stall-cycle limit (0 disables the watchdog)
//   s0_*, s1_*              channel AXI-Stream slaves (tdata/tvalid/tready)
//   m_*                     DMA AXI-Stream master (tdata/tvalid/tready/tlast/tuser)
//   busy                    a packet is in progress
//   pkt_count               completed packets, wraps modulo 2^32
//   block, block_info       watchdog trip flag and cause
//                           ([1:0] ch0, [3:2] ch1; bit0 starve, bit1 backpressure)
module ad2dma_stream_arbiter #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int TMO_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_enable,
    input  logic [LEN_W-1:0]  cfg_pkt_len,
    input  logic [TMO_W-1:0]  cfg_timeout,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              m_tuser,
    output logic              busy,
    output logic [31:0]       pkt_count,
    output logic              block,
    output logic [3:0]        block_info
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};

    state_t             state_r;
    state_t             state_next_s;
    logic               sel_r;
    logic               last_grant_r;
    logic [LEN_W-1:0]   len_q_r;
    logic [LEN_W-1:0]   beat_cnt_r;
    logic [TMO_W-1:0]   stall_cnt_r;
    logic [TMO_W:0]     stall_inc_s;
    logic [31:0]        pkt_count_r;
    logic               block_r;
    logic [3:0]         block_info_r;
    logic               grant_s;
    logic               grant_ch_s;
    logic               sel_valid_s;
    logic               last_beat_s;
    logic               accept_s;
    logic [3:0]         trip_info_s;

    // Two-bit stall cause for one channel: {downstream backpressure, upstream starve}.
    function automatic logic [1:0] stall_code(input logic ready, input logic valid);
        return {~ready, ~valid};
    endfunction

    // Next-state logic and round-robin channel selection.
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        grant_ch_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_enable && (s0_tvalid || s1_tvalid)) begin
                    grant_s      = 1'b1;
                    state_next_s = ST_BURST;
                    if (s0_tvalid && s1_tvalid) begin
                        grant_ch_s = ~last_grant_r;
                    end else begin
                        grant_ch_s = s1_tvalid;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (accept_s && last_beat_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BURST;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Zero-latency pass-through of the selected channel while a packet is open.
    always_comb begin
        m_tdata     = {DATA_W{1'b0}};
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        m_tuser     = 1'b0;
        s0_tready   = 1'b0;
        s1_tready   = 1'b0;
        sel_valid_s = sel_r ? s1_tvalid : s0_tvalid;
        last_beat_s = (beat_cnt_r == (len_q_r - LEN_ONE));
        accept_s    = 1'b0;
        trip_info_s = sel_r ? {stall_code(m_tready, s1_tvalid), 2'b00}
                            : {2'b00, stall_code(m_tready, s0_tvalid)};
        if (state_r == ST_BURST) begin
            m_tdata   = sel_r ? s1_tdata : s0_tdata;
            m_tvalid  = sel_valid_s;
            m_tlast   = last_beat_s;
            m_tuser   = sel_r;
            s0_tready = ~sel_r & m_tready;
            s1_tready = sel_r & m_tready;
            accept_s  = sel_valid_s & m_tready;
        end else begin
            accept_s  = 1'b0;
        end
    end

    // State register, packet latch, beat counter and packet counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            sel_r        <= 1'b0;
            last_grant_r <= 1'b1;
            len_q_r      <= LEN_ONE;
            beat_cnt_r   <= {LEN_W{1'b0}};
            pkt_count_r  <= 32'd0;
        end else begin
            state_r <= state_next_s;
            if (grant_s) begin
                sel_r      <= grant_ch_s;
                len_q_r    <= (cfg_pkt_len == {LEN_W{1'b0}}) ? LEN_ONE : cfg_pkt_len;
                beat_cnt_r <= {LEN_W{1'b0}};
            end else if (accept_s) begin
                beat_cnt_r <= beat_cnt_r + LEN_ONE;
                if (last_beat_s) begin
                    last_grant_r <= sel_r;
                    pkt_count_r  <= pkt_count_r + 32'd1;
                end
            end
        end
    end

    assign stall_inc_s = {1'b0, stall_cnt_r} + {{TMO_W{1'b0}}, 1'b1};

    // Stall watchdog: counts non-accepting BURST cycles, trips once at the limit
    // and holds its report until the next accept. An accept always wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_r  <= TMO_ZERO;
            block_r      <= 1'b0;
            block_info_r <= 4'b0000;
        end else if (grant_s || accept_s) begin
            stall_cnt_r  <= TMO_ZERO;
            block_r      <= 1'b0;
            block_info_r <= 4'b0000;
        end else if ((state_r == ST_BURST) && (cfg_timeout != TMO_ZERO)) begin
            if (stall_cnt_r >= cfg_timeout) begin
                // Limit lowered below the running count: saturate and trip if not yet.
                stall_cnt_r <= cfg_timeout;
                if (!block_r) begin
                    block_r      <= 1'b1;
                    block_info_r <= trip_info_s;
                end
            end else begin
                stall_cnt_r <= stall_inc_s[TMO_W-1:0];
                if (stall_inc_s == {1'b0, cfg_timeout}) begin
                    block_r      <= 1'b1;
                    block_info_r <= trip_info_s;
                end
            end
        end
    end

    assign busy       = (state_r == ST_BURST);
    assign pkt_count  = pkt_count_r;
    assign block      = block_r;
    assign block_info = block_info_r;

endmodule

// File: tb/tb_ad2dma_stream_arbiter.sv
module tb_ad2dma_stream_arbiter;

    localparam logic [31:0] D0 = 32'hA5A5_0000;
    localparam logic [31:0] D1 = 32'h5A5A_1111;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_enable = 1'b0;
    logic [15:0] cfg_pkt_len = 16'd0;
    logic [15:0] cfg_timeout = 16'd0;
    logic [31:0] s0_tdata = D0;
    logic        s0_tvalid = 1'b0;
    logic        s0_tready;
    logic [31:0] s1_tdata = D1;
    logic        s1_tvalid = 1'b0;
    logic        s1_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic        m_tuser;
    logic        busy;
    logic [31:0] pkt_count;
    logic        block;
    logic [3:0]  block_info;

    int checks = 0;
    int errors = 0;

    ad2dma_stream_arbiter #(.DATA_W(32), .LEN_W(16), .TMO_W(16)) dut (
        .clock(clock), .reset(reset),
        .cfg_enable(cfg_enable), .cfg_pkt_len(cfg_pkt_len), .cfg_timeout(cfg_timeout),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser), .busy(busy), .pkt_count(pkt_count),
        .block(block), .block_info(block_info)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        s0v, s1v, mrdy;
        logic [15:0] len;
        logic        mv, tuser, tlast, r0, r1, bsy;
        logic [31:0] pkt, data;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input int s0v, input int s1v, input int mr, input int len,
                                input int mv, input int tu, input int tl, input int r0,
                                input int r1, input int bz, input int pkt, input logic [31:0] data);
        vec_t v;
        v.s0v = 1'(s0v); v.s1v = 1'(s1v); v.mrdy = 1'(mr); v.len = 16'(len);
        v.mv = 1'(mv); v.tuser = 1'(tu); v.tlast = 1'(tl); v.r0 = 1'(r0);
        v.r1 = 1'(r1); v.bsy = 1'(bz); v.pkt = 32'(pkt); v.data = data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic en, input logic [15:0] len, input logic [15:0] tmo,
                          input logic v0, input logic v1, input logic mr);
        cfg_enable = en; cfg_pkt_len = len; cfg_timeout = tmo;
        s0_tvalid = v0; s1_tvalid = v1; m_tready = mr;
    endtask

    // Pulse reset and release it just after a rising edge; the DUT is then IDLE.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Round-robin packets of 4 beats, both channels valid, sink always ready.
        tbl[0]  = mk(1,1,1,4, 0,0,0,0,0,0, 0, 32'd0);
        tbl[1]  = mk(1,1,1,4, 1,0,0,1,0,1, 0, D0);
        tbl[2]  = mk(1,1,1,4, 1,0,0,1,0,1, 0, D0);
        tbl[3]  = mk(1,1,1,4, 1,0,0,1,0,1, 0, D0);
        tbl[4]  = mk(1,1,1,4, 1,0,1,1,0,1, 0, D0);
        tbl[5]  = mk(1,1,1,4, 0,0,0,0,0,0, 1, 32'd0);
        tbl[6]  = mk(1,1,1,4, 1,1,0,0,1,1, 1, D1);
        tbl[7]  = mk(1,1,1,4, 1,1,0,0,1,1, 1, D1);
        tbl[8]  = mk(1,1,1,4, 1,1,0,0,1,1, 1, D1);
        tbl[9]  = mk(1,1,1,4, 1,1,1,0,1,1, 1, D1);
        tbl[10] = mk(1,1,1,4, 0,0,0,0,0,0, 2, 32'd0);
        tbl[11] = mk(1,1,1,4, 1,0,0,1,0,1, 2, D0);
        tbl[12] = mk(1,1,1,4, 1,0,0,1,0,1, 2, D0);
        tbl[13] = mk(1,1,1,4, 1,0,0,1,0,1, 2, D0);
        tbl[14] = mk(1,1,1,4, 1,0,1,1,0,1, 2, D0);
        tbl[15] = mk(1,1,1,4, 0,0,0,0,0,0, 3, 32'd0);

        // Reset state while inputs are active.
        set_in(1'b1, 16'd4, 16'd0, 1'b1, 1'b1, 1'b1);
        #2;
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tlast",  32'(m_tlast),  32'd0);
        check("rst_s0_tready", 32'(s0_tready), 32'd0);
        check("rst_s1_tready", 32'(s1_tready), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_pkt",      pkt_count,     32'd0);
        check("rst_block",    32'({block, block_info}), 32'd0);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            s0_tvalid = tbl[i].s0v; s1_tvalid = tbl[i].s1v;
            m_tready = tbl[i].mrdy; cfg_pkt_len = tbl[i].len;
            @(negedge clock);
            check($sformatf("rr%0d_tvalid", i), 32'(m_tvalid), 32'(tbl[i].mv));
            check($sformatf("rr%0d_tuser", i),  32'(m_tuser),  32'(tbl[i].tuser));
            check($sformatf("rr%0d_tlast", i),  32'(m_tlast),  32'(tbl[i].tlast));
            check($sformatf("rr%0d_ready", i),  32'({s1_tready, s0_tready}),
                  32'({tbl[i].r1, tbl[i].r0}));
            check($sformatf("rr%0d_busy", i),   32'(busy),     32'(tbl[i].bsy));
            check($sformatf("rr%0d_pkt", i),    pkt_count,     tbl[i].pkt);
            check($sformatf("rr%0d_data", i),   m_tdata,       tbl[i].data);
            step();
        end

        // Only ch1 valid, 3-beat packets: ch1 granted repeatedly.
        set_in(1'b1, 16'd3, 16'd0, 1'b0, 1'b1, 1'b1);
        do_reset();
        for (int p = 0; p < 2; p++) begin
            @(negedge clock);
            check("one_idle_busy", 32'(busy), 32'd0);
            step();
            for (int b = 0; b < 3; b++) begin
                @(negedge clock);
                check("one_tuser", 32'(m_tuser), 32'd1);
                check("one_ready", 32'({s1_tready, s0_tready}), 32'd2);
                check("one_tlast", 32'(m_tlast), 32'(b == 2));
                step();
            end
        end
        check("one_pkt", pkt_count, 32'd2);

        // Packet length 0 acts as 1: every beat is last, grants alternate.
        set_in(1'b1, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("len0_idle", 32'(busy), 32'd0);
            step();
            @(negedge clock);
            check("len0_tlast", 32'(m_tlast), 32'd1);
            check("len0_tuser", 32'(m_tuser), 32'(k % 2));
            step();
        end

        // Watchdog, ch0 starves after its first beat.
        set_in(1'b1, 16'd4, 16'd5, 1'b1, 1'b0, 1'b1);
        do_reset();
        step();
        step();
        s0_tvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("wd0_pre_block", 32'(block), 32'd0);
            step();
        end
        @(negedge clock);
        check("wd0_block", 32'(block), 32'd1);
        check("wd0_info", 32'(block_info), 32'h1);
        s0_tvalid = 1'b1;
        #1;
        check("wd0_accept", 32'(m_tvalid & m_tready), 32'd1);
        step();
        @(negedge clock);
        check("wd0_clear", 32'({block, block_info}), 32'd0);

        // Watchdog, ch1 backpressured by the sink.
        set_in(1'b1, 16'd4, 16'd5, 1'b0, 1'b1, 1'b0);
        do_reset();
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("wd1_pre_block", 32'(block), 32'd0);
            step();
        end
        @(negedge clock);
        check("wd1_block", 32'(block), 32'd1);
        check("wd1_info", 32'(block_info), 32'h8);
        check("wd1_s1_tready", 32'(s1_tready), 32'd0);
        check("wd1_tuser", 32'(m_tuser), 32'd1);

        // Watchdog disabled: never trips.
        set_in(1'b1, 16'd4, 16'd0, 1'b0, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clock);
            check("wd_off_block", 32'({block, block_info}), 32'd0);
        end

        // Mid-packet config changes do not shorten the current packet.
        set_in(1'b1, 16'd8, 16'd0, 1'b1, 1'b1, 1'b1);
        do_reset();
        step();
        for (int b = 0; b < 8; b++) begin
            if (b == 2) begin
                cfg_pkt_len = 16'd2;
                cfg_enable = 1'b0;
            end
            @(negedge clock);
            check("mid_tlast", 32'(m_tlast), 32'(b == 7));
            check("mid_busy", 32'(busy), 32'd1);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("mid_idle", 32'({busy, m_tvalid}), 32'd0);
            step();
        end
        check("mid_pkt", pkt_count, 32'd1);

        // Reset in the middle of a ch1 packet clears outputs at once.
        cfg_enable = 1'b1;
        cfg_pkt_len = 16'd8;
        step();
        step();
        @(negedge clock);
        check("ar_pre_tvalid", 32'({m_tvalid, m_tuser}), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("ar_tvalid", 32'(m_tvalid), 32'd0);
        check("ar_ready", 32'({s1_tready, s0_tready}), 32'd0);
        check("ar_tlast", 32'(m_tlast), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_pkt", pkt_count, 32'd0);
        step();
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
